// File: rtl/iob_iob2wishbone_tmo_pkg.sv
// Shared types for the IOb-to-Wishbone bridge: FSM state encoding and error counter width.
package iob_wb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/iob_iob2wishbone_tmo_if.sv
// IOb request/response and Wishbone master signals of the bridge, grouped as one bundle.
interface iob_iob2wishbone_tmo_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   import iob_wb_pkg::*;

   logic                    valid_i;
   logic [ADDR_W-1:0]       address_i;
   logic [DATA_W-1:0]       wdata_i;
   logic [DATA_W/8-1:0]     wstrb_i;
   logic [DATA_W-1:0]       rdata_o;
   logic                    ready_o;
   logic                    err_o;
   logic                    tmo_o;
   logic                    busy_o;
   logic [ERR_CNT_W-1:0]    err_cnt_o;

   logic [ADDR_W-1:0]       wb_addr_o;
   logic [DATA_W-1:0]       wb_data_o;
   logic [DATA_W/8-1:0]     wb_select_o;
   logic                    wb_we_o;
   logic                    wb_cyc_o;
   logic                    wb_stb_o;
   logic                    wb_ack_i;
   logic                    wb_error_i;
   logic [DATA_W-1:0]       wb_data_i;

   // Bridge side.
   modport master (
      input  valid_i, address_i, wdata_i, wstrb_i,
      output rdata_o, ready_o, err_o, tmo_o, busy_o, err_cnt_o,
      output wb_addr_o, wb_data_o, wb_select_o, wb_we_o, wb_cyc_o, wb_stb_o,
      input  wb_ack_i, wb_error_i, wb_data_i
   );

   // Environment side: IOb master plus Wishbone slave.
   modport slave (
      output valid_i, address_i, wdata_i, wstrb_i,
      input  rdata_o, ready_o, err_o, tmo_o, busy_o, err_cnt_o,
      input  wb_addr_o, wb_data_o, wb_select_o, wb_we_o, wb_cyc_o, wb_stb_o,
      output wb_ack_i, wb_error_i, wb_data_i
   );

endinterface

// File: rtl/iob_iob2wishbone_tmo_timeout.sv
// Bounded-wait counter for the Wishbone BUSY phase; hit marks the last allowed wait cycle.
module iob_wb_timeout #(
   parameter int unsigned TIMEOUT   = 255,
   parameter int unsigned TIMEOUT_W = 8
) (
   input  logic clk_i,
   input  logic arst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic hit_o
);

   localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + TIMEOUT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (arst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   generate
      if (TIMEOUT == 0) begin : g_off
         assign hit_o = 1'b0;
      end else begin : g_on
         assign hit_o = (cnt_q == LAST);
      end
   endgenerate

endmodule

// File: rtl/iob_iob2wishbone_tmo.sv
// IOb-to-Wishbone master bridge: one transaction in flight, bounded wait, optional registered response.
module iob_iob2wishbone_tmo
   import iob_wb_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned TIMEOUT   = 255,
   parameter int unsigned TIMEOUT_W = 8,
   parameter int unsigned RESP_REG  = 0
) (
   input logic                       clk_i,
   input logic                       arst_i,
   iob_iob2wishbone_tmo_if.master    bus
);

   localparam int unsigned STRB_W = DATA_W / 8;

   state_e                 state_q, state_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [DATA_W-1:0]      wdata_q, wdata_d;
   logic [STRB_W-1:0]      wstrb_q, wstrb_d;
   logic [DATA_W-1:0]      rdata_q, rdata_d;
   logic                   err_q, err_d;
   logic                   tmo_q, tmo_d;
   logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

   logic                   in_busy;
   logic                   tmo_raw;
   logic                   tmo_hit;
   logic                   term;
   logic [DATA_W-1:0]      term_rdata;
   logic                   ready;
   logic                   err_out;
   logic                   tmo_out;
   logic [DATA_W-1:0]      rdata_out;

   assign in_busy = (state_q == BUSY);

   iob_wb_timeout #(
      .TIMEOUT   (TIMEOUT),
      .TIMEOUT_W (TIMEOUT_W)
   ) u_timeout (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .clr_i  (!in_busy),
      .en_i   (in_busy && !term),
      .hit_o  (tmo_raw)
   );

   // Error wins over a simultaneous ack; only a clean ack returns data.
   always_comb begin
      tmo_hit    = in_busy && tmo_raw && !bus.wb_ack_i && !bus.wb_error_i;
      term       = in_busy && (bus.wb_ack_i || bus.wb_error_i || tmo_hit);
      term_rdata = (bus.wb_ack_i && !bus.wb_error_i) ? bus.wb_data_i : '0;
   end

   always_comb begin
      if (RESP_REG != 0) begin
         ready     = (state_q == RESP);
         rdata_out = ready ? rdata_q : '0;
         err_out   = ready && err_q;
         tmo_out   = ready && tmo_q;
      end else begin
         ready     = term;
         rdata_out = term ? term_rdata : '0;
         err_out   = in_busy && bus.wb_error_i;
         tmo_out   = tmo_hit;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      tmo_d     = tmo_q;
      err_cnt_d = err_cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.valid_i) begin
               addr_d  = bus.address_i;
               wdata_d = bus.wdata_i;
               wstrb_d = bus.wstrb_i;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (term) begin
               rdata_d = term_rdata;
               err_d   = bus.wb_error_i;
               tmo_d   = tmo_hit;
               state_d = (RESP_REG != 0) ? RESP : IDLE;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (ready && (err_out || tmo_out) && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (arst_i) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         tmo_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         tmo_q     <= tmo_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign bus.wb_addr_o   = addr_q;
   assign bus.wb_data_o   = wdata_q;
   assign bus.wb_we_o     = |wstrb_q;
   assign bus.wb_select_o = (|wstrb_q) ? wstrb_q : '1;
   assign bus.wb_cyc_o    = in_busy;
   assign bus.wb_stb_o    = in_busy;
   assign bus.busy_o      = (state_q != IDLE);
   assign bus.ready_o     = ready;
   assign bus.rdata_o     = rdata_out;
   assign bus.err_o       = err_out;
   assign bus.tmo_o       = tmo_out;
   assign bus.err_cnt_o   = err_cnt_q;

endmodule

// File: doc/iob_iob2wishbone_tmo.md
# iob_iob2wishbone_tmo

Parametrised IOb-to-Wishbone master bridge with a registered request stage, a bounded-wait timeout, optional registered response, and error and timeout reporting. It sits between an IOb master (CPU/DMA side) and a Wishbone B4 classic slave such as the MAC register and buffer-descriptor space. It holds one transaction in flight. A slave that never acks cannot hang the IOb side.

## Interface
Parameters:
- `ADDR_W`, default 32: address width, both sides.
- `DATA_W`, default 32: data width; multiple of 8.
- `TIMEOUT`, default 255: maximum Wishbone wait cycles. 0 disables the timeout.
- `TIMEOUT_W`, default 8: timeout counter width; must satisfy TIMEOUT < 2^TIMEOUT_W.
- `RESP_REG`, default 0: 1 registers ready/rdata/err/tmo.

Ports:
- `clk_i` in 1: clock.
- `arst_i` in 1: reset, synchronous, active-high.
- `valid_i` in 1: IOb request strobe, single-cycle.
- `address_i` in ADDR_W: IOb address.
- `wdata_i` in DATA_W: IOb write data.
- `wstrb_i` in DATA_W/8: write strobes; all-zero means read.
- `rdata_o` out DATA_W: read data.
- `ready_o` out 1: transaction complete, single-cycle pulse.
- `err_o` out 1: slave error; valid with ready_o.
- `tmo_o` out 1: timeout; valid with ready_o.
- `busy_o` out 1: transaction in flight, i.e. state ≠ IDLE.
- `err_cnt_o` out 8: saturating count of errored or timed-out transactions.
- `wb_addr_o` out ADDR_W, `wb_data_o` out DATA_W, `wb_select_o` out DATA_W/8, `wb_we_o` out 1, `wb_cyc_o` out 1, `wb_stb_o` out 1.
- `wb_ack_i` in 1, `wb_error_i` in 1, `wb_data_i` in DATA_W.

## Operation
- FSM states: IDLE, BUSY, RESP. RESP is used only when RESP_REG=1.
- **IDLE**
  - On `valid_i`: capture address, wdata, and wstrb into registers; go to BUSY.
  - `valid_i` in any other state is ignored. This is a protocol violation; no side effect.
- **Wishbone request outputs**
  - `wb_cyc_o` and `wb_stb_o` are 1 exactly while in BUSY.
  - `wb_we_o` is the OR of the captured wstrb.
  - `wb_select_o` is the captured wstrb when writing, all-ones when reading.
  - `wb_addr_o` and `wb_data_o` come from the capture registers. All are stable for the whole cycle.
- **BUSY termination.** The termination event is `wb_ack_i | wb_error_i | tmo_hit`.
  - `tmo_hit`: TIMEOUT≠0 and the counter equals TIMEOUT−1 with no ack and no err.
  - Counter clears on entry to BUSY and increments each BUSY cycle without termination.
- **RESP_REG=0**
  - In the termination cycle: `ready_o`=1, `rdata_o`=`wb_data_i`, `err_o`=`wb_error_i`, `tmo_o`=`tmo_hit`.
  - Next state is IDLE.
  - Outside termination, `rdata_o`=0.
- **RESP_REG=1**
  - Termination latches rdata (0 on error or timeout), err, and tmo; next state is RESP.
  - In RESP: `ready_o`=1 with the latched values; next state is IDLE.
- **Simultaneous `wb_ack_i` and `wb_error_i`:** treated as error: err_o=1, rdata 0.
- **Timeout:** rdata 0, tmo_o=1, err_o=0. The cycle is dropped; a late ack in IDLE is ignored.
- **err_cnt_o:** increments by 1 when ready_o coincides with err_o|tmo_o. It saturates at 255 and is cleared only by reset.
- **Reset:** state IDLE, all capture registers and the counter cleared. A reset mid-transaction aborts it with no ready_o pulse.

## Timing
- Reset values: all outputs 0 except `wb_select_o`, which is all-ones (read default).
- Request latency: `wb_stb_o` rises the cycle after `valid_i`.
- Zero-wait slave (ack in the first BUSY cycle): ready_o 1 cycle after valid_i with RESP_REG=0, 2 cycles with RESP_REG=1.
- Slave with N wait states: ready_o at 1+N cycles, plus 1 if RESP_REG=1.
- Timeout: with TIMEOUT=T, ready_o/tmo_o at cycle T after valid_i, plus 1 if RESP_REG=1. `wb_cyc_o` is low the following cycle.
- Back-to-back: a new `valid_i` is accepted the cycle after ready_o. Throughput is one transaction per 2 cycles minimum (RESP_REG=0).

## Structure
- Package `iob_wb_pkg` holds:
  - state encodings IDLE=2'd0, BUSY=2'd1, RESP=2'd2;
  - `ERR_CNT_W`=8.
- One sub-module: `iob_wb_timeout`. It is the TIMEOUT_W counter with clear/enable and a hit output. Its hit output is constant 0 when TIMEOUT=0.
- The FSM, capture registers, and response registers live in the top module.

## Test plan
- **Read, zero wait, RESP_REG=0:** valid_i with addr 0x40, wstrb 0; slave acks in the first cycle with 0xDEADBEEF.
  - stb asserted at +1 with we=0 and sel=0xF.
  - ready_o at +1, rdata 0xDEADBEEF, err_o=0, tmo_o=0.
- **Write, 3 wait states, RESP_REG=1:** addr 0x44, wdata 0x12345678, wstrb 0x3.
  - we=1, sel=0x3, stb high for 4 cycles.
  - ready_o at +5.
  - err_cnt_o unchanged.
- **Slave error with simultaneous ack:**
  - ready_o with err_o=1 and rdata 0.
  - err_cnt_o 0→1.
- **Timeout, TIMEOUT=8, slave silent:**
  - stb high for 8 cycles; ready_o and tmo_o at +8.
  - A late ack at +10 is ignored, with no second ready_o.
- **Robustness:**
  - valid_i pulsed while busy_o=1 is ignored.
  - arst_i asserted mid-BUSY: cyc and stb low the next cycle, no ready_o.
  - 300 forced errors: err_cnt_o saturates at 255.
